minterm_sweeper: RTL and testbench

Sequential stimulus/capture stage that sits directly upstream of a 3-input combinational function block (`fxyz`-style: output `s`, inputs `x`, `y`, `z`). On a start pulse it drives the function's inputs through all 8 minterms and holds each for a programmable settle time. It samples `s` at the end of each hold and assembles the 8-bit truth table. It then compares the table against an expected value and reports pass/fail and a mismatch count, turning the exhaustive truth-table check into synthesizable hardware.

---
 rtl/minterm_sweeper.sv | 87 ++++++++
 tb/tb_minterm_sweeper.sv | 130 +++++++++++++
 2 files changed

// File: rtl/minterm_sweeper.sv
// minterm_sweeper: drives a 3-input function through all 8 minterms, captures its truth table and checks it
// Ports: clk, rst_n (async active-low), start (sweep request, IDLE only), s (function output)
//        x/y/z (current minterm), busy (sweeping), done (1-cycle completion pulse),
//        table_out (captured table, bit i = s at minterm i), pass (table_out == EXPECT), err_count (mismatching bits)
// Option: define MINTERM_SWEEP_GRAY_EN to visit minterms in Gray order (results still stored by minterm value)
module minterm_sweeper #(
    parameter int         SETTLE = 2,
    parameter logic [7:0] EXPECT = 8'h45
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [3:0] err_count
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] idx, mt;
    logic [3:0] cnt;
    logic       last;
    logic [7:0] tbl_nxt;
`ifdef MINTERM_SWEEP_GRAY_EN
    assign mt = idx ^ (idx >> 1);
`else
    assign mt = idx;
`endif
    assign last = cnt == 4'(SETTLE - 1);
    // table including the sample taken this cycle, so pass can be registered on entry to DONE
    always_comb begin
        tbl_nxt     = table_out;
        tbl_nxt[mt] = s;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        {x, y, z} = 3'b000;
        case (state)
            IDLE:    state_nxt = start ? SWEEP : IDLE;
            SWEEP: begin
                busy      = 1'b1;
                {x, y, z} = mt;
                state_nxt = (last && idx == 3'd7) ? DONE : SWEEP;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            table_out <= '0;
            pass      <= 1'b0;
            err_count <= '0;
        end else if (state == IDLE && start) begin
            idx       <= '0;
            cnt       <= '0;
            table_out <= '0;
            pass      <= 1'b0;
            err_count <= '0;
        end else if (state == SWEEP) begin
            if (last) begin
                table_out <= tbl_nxt;
                cnt       <= '0;
                idx       <= idx + 3'd1;
                if (s != EXPECT[mt]) err_count <= err_count + 4'd1;
                if (idx == 3'd7) pass <= tbl_nxt == EXPECT;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper: directed and random sweeps of two sweepers (SETTLE=2 and SETTLE=1) against a truth-table model
module tb_minterm_sweeper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] fn = 8'h45;
    logic       xa, ya, za, busy_a, done_a, pass_a, xb, yb, zb, busy_b, done_b, pass_b;
    logic [7:0] tbl_a, tbl_b;
    logic [3:0] err_a, err_b;
    logic       s_a, s_b, start_a, start_b;
    logic       busy_c, done_c, pass_c;
    logic [2:0] xyz_c;
    logic [7:0] tbl_c;
    logic [3:0] err_c;
    int         checks = 0;
    int         errors = 0;
    int         ord[8];

    always #5 clk = ~clk;

    // the function block under sweep is modelled as a lookup of the chosen truth table
    assign s_a     = fn[{xa, ya, za}];
    assign s_b     = fn[{xb, yb, zb}];
    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign busy_c  = sel ? busy_b : busy_a;
    assign done_c  = sel ? done_b : done_a;
    assign pass_c  = sel ? pass_b : pass_a;
    assign xyz_c   = sel ? {xb, yb, zb} : {xa, ya, za};
    assign tbl_c   = sel ? tbl_b : tbl_a;
    assign err_c   = sel ? err_b : err_a;

    minterm_sweeper #(.SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .s(s_a), .x(xa), .y(ya), .z(za),
        .busy(busy_a), .done(done_a), .table_out(tbl_a), .pass(pass_a), .err_count(err_a)
    );
    minterm_sweeper #(.SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .s(s_b), .x(xb), .y(yb), .z(zb),
        .busy(busy_b), .done(done_b), .table_out(tbl_b), .pass(pass_b), .err_count(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_busy"}, {busy_a, busy_b}, 0);
        chk({tag, "_done"}, {done_a, done_b}, 0);
        chk({tag, "_xyz"}, {xa, ya, za, xb, yb, zb}, 0);
        chk({tag, "_tbl"}, {tbl_a, tbl_b}, 0);
        chk({tag, "_pass"}, {pass_a, pass_b}, 0);
        chk({tag, "_err"}, {err_a, err_b}, 0);
    endtask

    // called at a negedge; start is seen at the following edge E0
    task automatic run(input logic sb, input logic [7:0] f, input bit rep, input bit abort);
        int st, k;
        st    = sb ? 1 : 2;
        sel   = sb;
        fn    = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_tbl", tbl_c, 0);
        chk("clr_err", err_c, 0);
        chk("clr_pass", pass_c, 0);
        k = 0;
        while (done_c !== 1'b1 && k < 40) begin
            if (abort && k == 7) begin
                rst_n = 1'b0;
                #1;
                check_idle_reset("abort");
                @(negedge clk);
                chk("abort_nodone", done_c, 0);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_abort_idle", {busy_c, done_c}, 0);
                end
                return;
            end
            chk("busy", busy_c, 1);
            chk("xyz", xyz_c, ord[(k / st) % 8]);
            start = rep && (k == 2 || k == 9);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("latency", k, 8 * st);
        chk("done_busy", busy_c, 0);
        chk("done_xyz", xyz_c, 0);
        chk("table", tbl_c, f);
        chk("pass", pass_c, f == 8'h45);
        chk("err_count", err_c, $countones(f ^ 8'h45));
        @(negedge clk);
        chk("done_pulse", done_c, 0);
        chk("idle_busy", busy_c, 0);
        chk("hold_tbl", tbl_c, f);
        chk("hold_err", err_c, $countones(f ^ 8'h45));
    endtask

    initial begin
`ifdef MINTERM_SWEEP_GRAY_EN
        ord = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
        ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset("post_reset");
        run(1'b0, 8'h45, 0, 0);
        run(1'b0, 8'h00, 0, 0);
        run(1'b0, 8'hBA, 0, 0);
        run(1'b1, 8'h45, 0, 0);
        run(1'b0, 8'h45, 1, 0);
        run(1'b0, 8'h3C, 0, 0);
        run(1'b0, 8'hBA, 0, 1);
        run(1'b0, 8'h45, 0, 0);
        repeat (10) run(1'($urandom_range(0, 1)), 8'($urandom), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
